// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared state encoding and defaults for the PLL reset sequencer
package pll_rst_pkg;

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_STABLE    = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  localparam int STABLE_CYCLES_DEF   = 2048;
  localparam int POST_RST_CYCLES_DEF = 16;

  // one counter serves both timed phases, so it is sized for the longer one
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return ($clog2(m) > 0) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-flop synchronizer with async reset for single-bit CDC inputs
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // shift the asynchronous input through the flop chain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d_i};

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: holds the PLL-domain reset until lock is stable and tracks lock losses
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int STABLE_CYCLES   = STABLE_CYCLES_DEF,
  parameter int POST_RST_CYCLES = POST_RST_CYCLES_DEF,
  parameter int LOSS_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_locked_i,
  input  logic              sw_reset_req,
  input  logic              clear_sticky,
  output logic              sys_rst_n,
  output logic              clk_ready,
  output logic              lock_lost,
  output logic [LOSS_W-1:0] loss_cnt
);

  localparam int CW = cnt_width(STABLE_CYCLES, POST_RST_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] POST_LAST   = CW'(POST_RST_CYCLES - 1);

  logic              lock_s;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              run_q;
  logic              lost_q, lost_d;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d, loss_base;
  logic              loss_ev;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (pll_locked_i),
    .q_o   (lock_s)
  );

  // next-state and shared counter; a lock drop always beats a software reset request
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    loss_ev = 1'b0;
    case (state_q)
      S_WAIT_LOCK: begin
        cnt_d   = '0;
        state_d = lock_s ? S_STABLE : S_WAIT_LOCK;
      end
      S_STABLE: begin
        state_d = !lock_s ? S_WAIT_LOCK : (cnt_q == STABLE_LAST) ? S_RELEASE : S_STABLE;
        cnt_d   = (!lock_s || cnt_q == STABLE_LAST) ? '0 : cnt_q + 1'b1;
      end
      S_RELEASE: begin
        state_d = !lock_s ? S_WAIT_LOCK : (cnt_q == POST_LAST) ? S_RUN : S_RELEASE;
        cnt_d   = (!lock_s || cnt_q == POST_LAST) ? '0 : cnt_q + 1'b1;
      end
      default: begin
        loss_ev = !lock_s;
        state_d = !lock_s ? S_WAIT_LOCK : sw_reset_req ? S_RELEASE : S_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // sticky loss flag and saturating counter; a simultaneous loss survives a clear
  always_comb begin
    loss_base  = clear_sticky ? '0 : loss_cnt_q;
    lost_d     = loss_ev | (lost_q & ~clear_sticky);
    loss_cnt_d = (loss_ev && loss_base != '1) ? loss_base + 1'b1 : loss_base;
  end

  // state registers; the reset output is a registered decode of the next state so it cannot glitch
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= S_WAIT_LOCK;
      cnt_q      <= '0;
      run_q      <= 1'b0;
      lost_q     <= 1'b0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_q      <= (state_d == S_RUN);
      lost_q     <= lost_d;
      loss_cnt_q <= loss_cnt_d;
    end

  assign sys_rst_n = run_q;
  assign clk_ready = run_q;
  assign lock_lost = lost_q;
  assign loss_cnt  = loss_cnt_q;

endmodule
